// File: rtl/synth_key_pkg.sv
// Shared keypad/synth definitions used by the encoder, decoder and oscillator blocks.
package synth_key_pkg;

    localparam logic [3:0]  KEY_IDLE     = 4'd0;
    localparam logic [3:0]  KEY_NOTE_MAX = 4'd13;
    localparam int unsigned NUM_NOTES    = 13;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SINE   = 2'd3
    } wave_mode_e;

    // Note n (1..13) maps to bit n-1; idle or out-of-range codes give all zeros.
    function automatic logic [NUM_NOTES-1:0] note_to_onehot(input logic [3:0] note);
        logic [NUM_NOTES-1:0] oh;
        oh = '0;
        if (note != KEY_IDLE && note <= KEY_NOTE_MAX) begin
            oh[note - 4'd1] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Holds a candidate value until it has been stable for STABLE_CYCLES edges, then accepts it.
// accept is a combinational strobe: acc takes the value of cand on this same edge.
module key_debouncer #(
    parameter int unsigned WIDTH         = 5,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] cand,
    output logic             accept
);

    localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Restart on any change, count up to saturation, accept once the count is full.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        accept = 1'b0;
        if (din != cand_q) begin
            cand_d = din;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cand_q != acc_q) begin
            acc_d  = cand_q;
            accept = 1'b1;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cand_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
        end
    end

    assign acc  = acc_q;
    assign cand = cand_q;

endmodule

// File: rtl/keypad_decoder.sv
// Turns debounced keypad state into note on/off events, a sounding-note vector and a
// waveform-mode register advanced by the mode key.
module keypad_decoder
    import synth_key_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned NUM_MODES     = 4,
    parameter int unsigned MODE_W        = $clog2(NUM_MODES)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [3:0]           keycode,
    input  logic                 modekey,
    output logic [NUM_NOTES-1:0] note_onehot,
    output logic                 note_valid,
    output logic                 note_on,
    output logic                 note_off,
    output logic [3:0]           note_idx,
    output logic [MODE_W-1:0]    mode,
    output logic                 mode_change
);

    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    typedef enum logic [1:0] {StIdle, StSounding, StPendOn} state_e;

    logic [3:0] note_in;
    logic [4:0] acc, cand;
    logic       accept;

    // Mode key masks the note code; invalid codes read as idle.
    always_comb begin
        note_in = KEY_IDLE;
        if (!modekey && keycode != KEY_IDLE && keycode <= KEY_NOTE_MAX) begin
            note_in = keycode;
        end
    end

    key_debouncer #(
        .WIDTH        (5),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .n_rst (n_rst),
        .din   ({modekey, note_in}),
        .acc   (acc),
        .cand  (cand),
        .accept(accept)
    );

    state_e               state_q, state_d;
    logic [3:0]           pend_q, pend_d;
    logic [NUM_NOTES-1:0] onehot_q, onehot_d;
    logic                 on_q, on_d, off_q, off_d;
    logic [3:0]           idx_q, idx_d;
    logic [MODE_W-1:0]    mode_q, mode_d;
    logic                 mchg_q, mchg_d;

    // Event FSM and mode counter; a note-to-note switch emits off now and on next cycle.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        onehot_d = onehot_q;
        on_d     = 1'b0;
        off_d    = 1'b0;
        idx_d    = idx_q;
        mode_d   = mode_q;
        mchg_d   = 1'b0;

        if (state_q == StPendOn) begin
            on_d     = 1'b1;
            idx_d    = pend_q;
            onehot_d = note_to_onehot(pend_q);
            pend_d   = KEY_IDLE;
            state_d  = StSounding;
        end else if (accept && acc[3:0] != cand[3:0]) begin
            if (acc[3:0] == KEY_IDLE) begin
                on_d     = 1'b1;
                idx_d    = cand[3:0];
                onehot_d = note_to_onehot(cand[3:0]);
                state_d  = StSounding;
            end else begin
                off_d    = 1'b1;
                idx_d    = acc[3:0];
                onehot_d = '0;
                if (cand[3:0] == KEY_IDLE) begin
                    state_d = StIdle;
                end else begin
                    pend_d  = cand[3:0];
                    state_d = StPendOn;
                end
            end
        end

        if (accept && cand[4] && !acc[4]) begin
            mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
            mchg_d = 1'b1;
        end
    end

    // Output and FSM registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= StIdle;
            pend_q   <= '0;
            onehot_q <= '0;
            on_q     <= 1'b0;
            off_q    <= 1'b0;
            idx_q    <= '0;
            mode_q   <= '0;
            mchg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            onehot_q <= onehot_d;
            on_q     <= on_d;
            off_q    <= off_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            mchg_q   <= mchg_d;
        end
    end

    assign note_onehot = onehot_q;
    assign note_valid  = |onehot_q;
    assign note_on     = on_q;
    assign note_off    = off_q;
    assign note_idx    = idx_q;
    assign mode        = mode_q;
    assign mode_change = mchg_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench for keypad_decoder with default parameters (STABLE_CYCLES=4, NUM_MODES=4).
module tb_keypad_decoder;

    logic        clk;
    logic        n_rst;
    logic [3:0]  keycode;
    logic        modekey;
    logic [12:0] note_onehot;
    logic        note_valid;
    logic        note_on;
    logic        note_off;
    logic [3:0]  note_idx;
    logic [1:0]  mode;
    logic        mode_change;

    int vectors = 0;
    int errors  = 0;
    int pulses;

    keypad_decoder dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .keycode    (keycode),
        .modekey    (modekey),
        .note_onehot(note_onehot),
        .note_valid (note_valid),
        .note_on    (note_on),
        .note_off   (note_off),
        .note_idx   (note_idx),
        .mode       (mode),
        .mode_change(mode_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("miscompare in %s", tag);
        end
    endtask

    // Advance n active edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_event(input string tag, input logic on, input logic off,
                               input logic [3:0] idx, input logic [12:0] oh);
        check({tag, ".on"},     32'(note_on),     32'(on));
        check({tag, ".off"},    32'(note_off),    32'(off));
        check({tag, ".idx"},    32'(note_idx),    32'(idx));
        check({tag, ".onehot"}, 32'(note_onehot), 32'(oh));
        check({tag, ".valid"},  32'(note_valid),  32'(oh != 13'h0));
    endtask

    initial begin
        n_rst   = 1'b0;
        keycode = 4'd5;
        modekey = 1'b0;
        #22;
        check_event("reset", 1'b0, 1'b0, 4'd0, 13'h0000);
        check("reset.mode", 32'(mode), 32'd0);
        check("reset.mchg", 32'(mode_change), 32'd0);

        // Key 5 held since reset: pulse visible right after edge 4.
        n_rst = 1'b1;
        tick(4);
        check_event("k5_early", 1'b0, 1'b0, 4'd0, 13'h0000);
        tick(1);
        check_event("k5_on", 1'b1, 1'b0, 4'd5, 13'h0010);
        tick(1);
        check_event("k5_hold", 1'b0, 1'b0, 4'd5, 13'h0010);

        keycode = 4'd0;
        tick(5);
        check_event("k5_off", 1'b0, 1'b1, 4'd5, 13'h0000);

        // Press and release 3.
        keycode = 4'd3;
        tick(5);
        check_event("k3_on", 1'b1, 1'b0, 4'd3, 13'h0004);
        keycode = 4'd0;
        tick(5);
        check_event("k3_off", 1'b0, 1'b1, 4'd3, 13'h0000);

        // Two-cycle glitch on 7 is rejected.
        keycode = 4'd7;
        tick(2);
        keycode = 4'd0;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            pulses += int'(note_on) + int'(note_off);
        end
        check("glitch.pulses", 32'(pulses), 32'd0);
        check("glitch.onehot", 32'(note_onehot), 32'd0);
        keycode = 4'd7;
        tick(5);
        check_event("k7_on", 1'b1, 1'b0, 4'd7, 13'h0040);

        // Direct switches 7 -> 2 -> 9.
        keycode = 4'd2;
        tick(5);
        check_event("sw72_off", 1'b0, 1'b1, 4'd7, 13'h0000);
        tick(1);
        check_event("sw72_on", 1'b1, 1'b0, 4'd2, 13'h0002);
        keycode = 4'd9;
        tick(5);
        check_event("sw29_off", 1'b0, 1'b1, 4'd2, 13'h0000);
        tick(1);
        check_event("sw29_on", 1'b1, 1'b0, 4'd9, 13'h0100);
        tick(1);
        check_event("sw29_hold", 1'b0, 1'b0, 4'd9, 13'h0100);

        // First mode press while 9 sounds: note_off and mode_change together.
        modekey = 1'b1;
        keycode = 4'd0;
        tick(5);
        check("m1.mchg", 32'(mode_change), 32'd1);
        check("m1.mode", 32'(mode), 32'd1);
        check_event("m1_noteoff", 1'b0, 1'b1, 4'd9, 13'h0000);
        tick(1);
        check("m1.mchg_end", 32'(mode_change), 32'd0);
        modekey = 1'b0;
        tick(6);
        check("m1.rel_mode", 32'(mode), 32'd1);
        check("m1.rel_mchg", 32'(mode_change), 32'd0);

        for (int p = 0; p < 3; p++) begin
            modekey = 1'b1;
            tick(5);
            check("mp.mchg", 32'(mode_change), 32'd1);
            check("mp.mode", 32'(mode), 32'((p + 2) % 4));
            tick(1);
            check("mp.mchg_end", 32'(mode_change), 32'd0);
            modekey = 1'b0;
            tick(6);
            check("mp.rel_mode", 32'(mode), 32'((p + 2) % 4));
        end

        // Long hold gives exactly one advance.
        modekey = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            pulses += int'(mode_change);
        end
        check("hold.pulses", 32'(pulses), 32'd1);
        check("hold.mode", 32'(mode), 32'd1);
        modekey = 1'b0;
        tick(6);
        check("hold.rel_mode", 32'(mode), 32'd1);

        // Invalid codes read as idle.
        keycode = 4'd14;
        pulses  = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            pulses += int'(note_on) + int'(note_off);
        end
        keycode = 4'd15;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            pulses += int'(note_on) + int'(note_off);
        end
        check("invalid.pulses", 32'(pulses), 32'd0);
        check("invalid.onehot", 32'(note_onehot), 32'd0);

        // Reset in the middle of a sounding note.
        keycode = 4'd6;
        tick(5);
        check_event("k6_on", 1'b1, 1'b0, 4'd6, 13'h0020);
        tick(1);
        #3;
        n_rst = 1'b0;
        #1;
        check_event("midrst", 1'b0, 1'b0, 4'd0, 13'h0000);
        check("midrst.mode", 32'(mode), 32'd0);
        keycode = 4'd0;
        #2;
        n_rst  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            pulses += int'(note_on) + int'(note_off) + int'(mode_change);
        end
        check("postrst.pulses", 32'(pulses), 32'd0);
        check("postrst.onehot", 32'(note_onehot), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/keypad_decoder.md
Name: keypad_decoder

Overview:
- Consumer side of the keypad encoder interface: accepts registered `keycode[3:0]` and `modekey` and debounces them.
- Converts the accepted key state into note events (note_on/note_off pulses plus note index) and a one-hot sounding-note vector for the oscillator bank.
- Maintains the waveform-mode register, which advances on each mode-key press.
- Sits between the keypad encoder and the oscillator/envelope logic of the synthesizer.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles an input value must be held before it is accepted; legal range ≥2.
- NUM_MODES, 4, number of waveform modes cycled by the mode key; legal range ≥2; MODE_W = $clog2(NUM_MODES).

Ports:
- clk  input  1  system clock
- n_rst  input  1  reset; asynchronous, active-low; clock clk
- keycode  input  4  encoder key code: 0 idle, 1..13 note keys, 14..15 invalid
- modekey  input  1  encoder mode-key flag
- note_onehot  output  13  bit (n-1) high while note n is sounding
- note_valid  output  1  OR-reduce of note_onehot
- note_on  output  1  one-cycle pulse: note note_idx starts
- note_off  output  1  one-cycle pulse: note note_idx stops
- note_idx  output  4  note number for the current pulse; holds its last value otherwise
- mode  output  MODE_W  current waveform mode
- mode_change  output  1  one-cycle pulse when mode advances

Behaviour:
- Reset (async, any time including mid-operation):
  - All outputs go to 0.
  - The candidate register, stability counter, accepted state and pending flag go to 0.
  - No pulses are issued on reset entry or exit.
- Input normalisation: `note_in = (modekey==0 && keycode in 1..13) ? keycode : 0`. Invalid codes 14/15 map to idle. While modekey=1, keycode is ignored.
- Debounce (per edge; candidate `cand = {modekey, note_in}`, counter `cnt`):
  - If the input differs from cand: load cand, set cnt=0.
  - Else if cnt != STABLE_CYCLES-1: increment cnt.
  - Else if cand != acc: acc <= cand and evaluate events in the same edge.
  - cnt saturates at STABLE_CYCLES-1; it never wraps.
- Latency: with an input first sampled at edge 0 and held stable, acc and event outputs update at edge STABLE_CYCLES. For the default, the pulse is visible in the cycle after edge 4.
- Flicker: any change before acceptance restarts the count. A glitch shorter than STABLE_CYCLES produces no event.
- Note events, for an acceptance changing the old note a to the new note b:
  - a==b: no note event.
  - a=0, b≠0: note_on=1, note_idx=b, bit b-1 of note_onehot set.
  - a≠0, b=0: note_off=1, note_idx=a, note_onehot cleared.
  - a≠0, b≠0, a≠b:
    - Cycle N: note_off with note_idx=a, note_onehot cleared, pending flag set.
    - Cycle N+1: note_on with note_idx=b, bit b-1 set, pending cleared.
  - note_on and note_off are never high in the same cycle.
  - Because STABLE_CYCLES≥2, no acceptance can collide with a pending note_on.
- Mode control:
  - On an acceptance where modekey rises 0→1: mode <= (mode==NUM_MODES-1) ? 0 : mode+1, and mode_change pulses for 1 cycle.
  - Holding the mode key gives exactly one advance.
  - A modekey 1→0 transition has no mode effect.
- Interaction between mode key and notes: a mode-key press while a note is active maps note_in to 0, so note_off for that note is issued in the same cycle as mode_change. This is legal; the two pulses are independent.
- note_valid is combinational from registered note_onehot. All other outputs are registered.

Decomposition:
- Package synth_key_pkg:
  - KEY_IDLE = 4'd0, KEY_NOTE_MAX = 4'd13, NUM_NOTES = 13.
  - Mode enum typedef: MODE_SQUARE=0, MODE_SAW=1, MODE_TRI=2, MODE_SINE=3.
  - Shared with the encoder and oscillator blocks.
- Sub-module key_debouncer, parameterised on width and STABLE_CYCLES: contains cand/cnt/acc and outputs the accepted value plus a one-cycle accept strobe. The top level holds the event FSM (IDLE, SOUNDING, PEND_ON) and the mode counter.

Test Plan:
- Reset: hold n_rst=0 with keycode=5 -> all outputs 0. Release, hold keycode=5 for 4 cycles -> note_on=1, note_idx=5, note_onehot=13'h0010 in the cycle after edge 4.
- Press 3 (held), then keycode 0 for 5 cycles -> note_on with idx 3 then note_off with idx 3, note_onehot returns to 0, note_valid=0.
- Glitch: keycode 7 held for 2 cycles then back to 0 -> no pulses, note_onehot stays 0. Then 7 held for 4 cycles -> note_on with idx 7.
- Direct switch: 2 stable, then 9 stable -> note_off idx 2 at cycle N, note_on idx 9 at N+1, note_onehot=13'h0100.
- Mode: 4 separate modekey presses (each held 6 cycles, released 6 cycles) with NUM_MODES=4 -> mode 1,2,3,0, four single-cycle mode_change pulses. A press held 20 cycles gives only one advance.
- Invalid code / reset mid-note: keycode 14 held -> no note_on. Note 6 sounding, then n_rst pulsed -> outputs immediately 0, no note_off pulse after release.
